// File: rtl/msrv32_dmem_access_unit.sv
// Data-memory access unit for the MSRV32 load/store stage: issues one registered
// bus request per load/store, formats lane data, and reports misalignment/timeout.
module msrv32_dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        start_in,
    input  logic        is_store_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic        dmem_ack_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [3:0]  dmem_wmask_out,
    output logic [31:0] dmem_wdata_out,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        done_out,
    output logic [1:0]  error_out
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic [1:0]  error_q, error_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;

    logic        misaligned;
    logic [3:0]  mask_fmt;
    logic [31:0] wdata_fmt;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    always_comb begin
        misaligned = ((load_size_in == 2'b01) && addr_in[0]) ||
                     (load_size_in[1] && (addr_in[1:0] != 2'b00));
        case (load_size_in)
            2'b00: begin
                mask_fmt  = 4'b0001 << addr_in[1:0];
                wdata_fmt = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                mask_fmt  = 4'b0011 << addr_in[1:0];
                wdata_fmt = {2{store_data_in[15:0]}};
            end
            default: begin
                mask_fmt  = 4'b1111;
                wdata_fmt = store_data_in;
            end
        endcase
    end

    // Load formatting uses the size/offset latched at issue, not the live inputs.
    always_comb begin
        case (off_q)
            2'd0:    byte_sel = dmem_rdata_in[7:0];
            2'd1:    byte_sel = dmem_rdata_in[15:8];
            2'd2:    byte_sel = dmem_rdata_in[23:16];
            default: byte_sel = dmem_rdata_in[31:24];
        endcase
        half_sel = off_q[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];
        case (size_q)
            2'b00:   load_fmt = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_fmt = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_fmt = dmem_rdata_in;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wmask_d     = wmask_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        done_d      = 1'b0;
        error_d     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    if (misaligned) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        error_d = 2'b01;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = 8'd0;
                        req_d   = 1'b1;
                        we_d    = is_store_in;
                        addr_d  = {addr_in[31:2], 2'b00};
                        wmask_d = is_store_in ? mask_fmt : 4'b0000;
                        wdata_d = wdata_fmt;
                        size_d  = load_size_in;
                        uns_d   = load_unsigned_in;
                        off_d   = addr_in[1:0];
                    end
                end
            end
            S_BUSY: begin
                if (dmem_ack_in) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        load_data_d = load_fmt;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    error_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wmask_q     <= 4'd0;
            wdata_q     <= 32'd0;
            load_data_q <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wmask_q     <= wmask_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
        end
    end

    assign dmem_req_out   = req_q;
    assign dmem_we_out    = we_q;
    assign dmem_addr_out  = addr_q;
    assign dmem_wmask_out = wmask_q;
    assign dmem_wdata_out = wdata_q;
    assign load_data_out  = load_data_q;
    assign done_out       = done_q;
    assign error_out      = error_q;
    assign stall_out      = ((state_q == S_IDLE) && start_in) || (state_q == S_BUSY);

endmodule

// File: tb/tb_msrv32_dmem_access_unit.sv
// Bench for msrv32_dmem_access_unit: directed and random loads/stores checked
// against an arithmetic reference model of lane selection, masks and timing.
module tb_msrv32_dmem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic        is_store_in = 1'b0;
    logic [1:0]  load_size_in = 2'b00;
    logic        load_unsigned_in = 1'b0;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] store_data_in = 32'd0;
    logic        dmem_ack_in = 1'b0;
    logic [31:0] dmem_rdata_in = 32'd0;
    logic        dmem_req_out, dmem_we_out, stall_out, done_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
    logic [3:0]  dmem_wmask_out;
    logic [1:0]  error_out;

    int tests = 0;
    int fails = 0;
    int op_no = 0;
    logic [31:0] model_ld = 32'd0;

    always #5 clk = ~clk;

    msrv32_dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk), .reset_in(reset_in), .start_in(start_in),
        .is_store_in(is_store_in), .load_size_in(load_size_in),
        .load_unsigned_in(load_unsigned_in), .addr_in(addr_in),
        .store_data_in(store_data_in), .dmem_ack_in(dmem_ack_in),
        .dmem_rdata_in(dmem_rdata_in), .dmem_req_out(dmem_req_out),
        .dmem_we_out(dmem_we_out), .dmem_addr_out(dmem_addr_out),
        .dmem_wmask_out(dmem_wmask_out), .dmem_wdata_out(dmem_wdata_out),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .done_out(done_out), .error_out(error_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit un,
                                             input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * int'(off))) & 32'hFF;
            if (!un && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'd1) begin
            v = off[1] ? (rd >> 16) : (rd & 32'hFFFF);
            if (!un && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_mask(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0) return 32'd1 << off;
        if (sz == 2'd1) return 32'd3 << off;
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] sd);
        if (sz == 2'd0) return (sd & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
        return sd;
    endfunction

    // ack_at: BUSY cycle (1-based) on which ack is given; outside 1..TO means never.
    task automatic do_op(input bit st, input logic [1:0] sz, input bit un,
                         input logic [31:0] ad, input logic [31:0] sd,
                         input logic [31:0] rd, input int ack_at);
        bit          mis, acked, got_done;
        int          exp_req, req_cnt, stall_cnt, cyc;
        logic [1:0]  exp_err;
        logic [31:0] exp_ld;
        mis     = ((sz == 2'd1) && ad[0]) || (sz[1] && (ad[1:0] != 2'd0));
        acked   = (ack_at >= 1) && (ack_at <= TO);
        exp_req = mis ? 0 : (acked ? ack_at : TO);
        exp_err = mis ? 2'd1 : (acked ? 2'd0 : 2'd2);
        exp_ld  = (!st && exp_err == 2'd0) ? ref_load(sz, un, ad[1:0], rd) : model_ld;
        req_cnt = 0;
        got_done = 0;

        @(negedge clk);
        start_in = 1'b1; is_store_in = st; load_size_in = sz;
        load_unsigned_in = un; addr_in = ad; store_data_in = sd; dmem_ack_in = 1'b0;
        #1;
        chk("stall_on_start", {31'd0, stall_out}, 32'd1);
        stall_cnt = stall_out ? 1 : 0;
        @(negedge clk);
        start_in = 1'b0;
        cyc = 1;
        while (!got_done && cyc < 40) begin
            if (done_out) begin
                got_done = 1;
            end else begin
                if (stall_out) stall_cnt++;
                if (dmem_req_out) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        chk("req_addr", dmem_addr_out, {ad[31:2], 2'b00});
                        chk("req_we", {31'd0, dmem_we_out}, {31'd0, st});
                        if (st) begin
                            chk("req_wmask", {28'd0, dmem_wmask_out}, ref_mask(sz, ad[1:0]));
                            chk("req_wdata", dmem_wdata_out, ref_wdata(sz, sd));
                        end
                    end
                end
                dmem_ack_in   = dmem_req_out && (req_cnt == ack_at);
                dmem_rdata_in = dmem_ack_in ? rd : $urandom;
                @(negedge clk);
                cyc++;
            end
        end
        dmem_ack_in = 1'b0;
        chk("done_seen", {31'd0, got_done}, 32'd1);
        chk("latency", cyc, exp_req + 1);
        chk("req_cycles", req_cnt, exp_req);
        chk("stall_cycles", stall_cnt, exp_req + 1);
        chk("error", {30'd0, error_out}, {30'd0, exp_err});
        chk("load_data", load_data_out, exp_ld);
        chk("req_at_done", {31'd0, dmem_req_out}, 32'd0);
        chk("stall_at_done", {31'd0, stall_out}, 32'd0);
        $display("[TB] op %0d store=%0d size=%0d uns=%0d addr=%h ack_at=%0d err=%0d ld=%h",
                 op_no, st, sz, un, ad, ack_at, error_out, load_data_out);
        op_no++;
        // ack outside BUSY must not disturb anything
        dmem_ack_in = 1'b1; dmem_rdata_in = $urandom;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done_out}, 32'd0);
        chk("error_idle", {30'd0, error_out}, 32'd0);
        dmem_ack_in = 1'b0;
        @(negedge clk);
        chk("load_hold", load_data_out, exp_ld);
        model_ld = exp_ld;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_req_out}, 32'd0);
        chk("rst_done", {31'd0, done_out}, 32'd0);
        chk("rst_ld", load_data_out, 32'd0);
        chk("rst_err", {30'd0, error_out}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        reset_in = 1'b0;

        do_op(0, 2'd0, 1, 32'h0000_0103, 32'd0, 32'h80FF_1234, 1);
        chk("byte_u_0x103", load_data_out, 32'h0000_0080);
        do_op(0, 2'd1, 0, 32'h0000_0202, 32'd0, 32'h8001_0000, 3);
        chk("half_s_0x202", load_data_out, 32'hFFFF_8001);
        do_op(1, 2'd0, 0, 32'h0000_0301, 32'h0000_00AB, 32'd0, 2);
        chk("store_keeps_ld", load_data_out, 32'hFFFF_8001);
        do_op(0, 2'd2, 0, 32'h0000_0402, 32'd0, 32'h1234_5678, 1);
        do_op(0, 2'd2, 0, 32'h0000_0400, 32'd0, 32'hDEAD_BEEF, 0);
        do_op(0, 2'd2, 0, 32'h0000_0400, 32'd0, 32'hCAFE_F00D, TO);
        chk("ack_on_last", load_data_out, 32'hCAFE_F00D);
        do_op(0, 2'd3, 1, 32'h0000_0404, 32'd0, 32'h0BAD_F00D, 2);
        do_op(1, 2'd1, 0, 32'h0000_0506, 32'h0000_BEEF, 32'd0, 1);

        // reset in the second BUSY cycle abandons the access
        @(negedge clk);
        start_in = 1'b1; is_store_in = 1'b0; load_size_in = 2'd2; addr_in = 32'h0000_0600;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", {31'd0, dmem_req_out}, 32'd1);
        reset_in = 1'b1;
        #1;
        chk("rst_drop_req", {31'd0, dmem_req_out}, 32'd0);
        chk("rst_drop_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_clear_ld", load_data_out, 32'd0);
        model_ld = 32'd0;
        @(negedge clk);
        reset_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", {31'd0, done_out}, 32'd0);
        end
        do_op(0, 2'd1, 1, 32'h0000_0702, 32'd0, 32'h9876_5432, 1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            s = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                if (s == 2'd1) a[0] = 1'b0;
                if (s[1]) a[1:0] = 2'b00;
            end
            do_op(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a,
                  $urandom, $urandom, $urandom_range(1, TO + 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
